alu_op_sequencer: RTL and testbench

Issue/capture front end for the combinational `alu`. It accepts operation requests over a valid/ready handshake and drives the ALU operand and select lines from registers. One cycle later it captures the 16-bit ALU result into a small result FIFO, which a consumer drains over a second valid/ready handshake. A chain mode feeds the low byte of the previous result back as the next X operand, with forwarding from the in-flight operation.

---
 rtl/alu_op_sequencer.sv | 119 +++++++++++
 tb/tb_alu_op_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Issue/capture front end for a combinational ALU: registers operands and
// selects on accept, captures the ALU result one cycle later into a small
// result FIFO, and supports chaining the previous result's low byte into X.
module alu_op_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_x,
    input  logic [7:0]  in_y,
    input  logic [1:0]  in_m,
    input  logic [1:0]  in_s,
    input  logic        in_chain,
    output logic [7:0]  alu_x,
    output logic [7:0]  alu_y,
    output logic [1:0]  alu_m,
    output logic [1:0]  alu_s,
    input  logic [15:0] alu_z,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_z,
    output logic [3:0]  out_op
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   count;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          exec_valid;
    logic [7:0]    acc;
    logic [19:0]   mem [DEPTH];

    logic          accept;
    logic          push;
    logic          pop;
    logic [7:0]    x_eff;
    logic [AW+1:0] occupancy;

    // Occupancy counts the in-flight op too, so a capture can never find the FIFO full.
    always_comb begin
        occupancy = {1'b0, count} + {{(AW+1){1'b0}}, exec_valid};
        in_ready  = occupancy < (AW+2)'(DEPTH);
        out_valid = (count != '0);
        accept    = in_valid && in_ready;
        push      = exec_valid;
        pop       = out_valid && out_ready;
    end

    // Chained X: forward from the op currently at the ALU, else the last captured low byte.
    always_comb begin
        x_eff = in_x;
        if (in_chain) begin
            x_eff = exec_valid ? alu_z[7:0] : acc;
        end
    end

    // Head entry is masked to zero while empty so stale contents never leak out.
    always_comb begin
        out_z  = 16'h0000;
        out_op = 4'h0;
        if (out_valid) begin
            out_z  = mem[rd_ptr][15:0];
            out_op = mem[rd_ptr][19:16];
        end
    end

    // Issue stage: load ALU operand/select registers on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_x      <= 8'h00;
            alu_y      <= 8'h00;
            alu_m      <= 2'b00;
            alu_s      <= 2'b00;
            exec_valid <= 1'b0;
        end else begin
            exec_valid <= accept;
            if (accept) begin
                alu_x <= x_eff;
                alu_y <= in_y;
                alu_m <= in_m;
                alu_s <= in_s;
            end
        end
    end

    // Capture stage and FIFO bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            acc    <= 8'h00;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                acc    <= alu_z[7:0];
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // FIFO storage is deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= {alu_s, alu_m, alu_z};
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: a behavioural ALU drives alu_z,
// and a queue-based reference model predicts handshake and result behaviour.
module tb_alu_op_sequencer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_x;
    logic [7:0]  in_y;
    logic [1:0]  in_m;
    logic [1:0]  in_s;
    logic        in_chain;
    logic [7:0]  alu_x;
    logic [7:0]  alu_y;
    logic [1:0]  alu_m;
    logic [1:0]  alu_s;
    logic [15:0] alu_z;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_z;
    logic [3:0]  out_op;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [19:0] exp_q[$];
    int          outstanding;
    bit          pend;
    logic [7:0]  pend_x;
    logic [7:0]  pend_y;
    logic [3:0]  pend_op;
    logic [7:0]  last_lo;

    always #5 clk = ~clk;

    alu_op_sequencer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_m      (in_m),
        .in_s      (in_s),
        .in_chain  (in_chain),
        .alu_x     (alu_x),
        .alu_y     (alu_y),
        .alu_m     (alu_m),
        .alu_s     (alu_s),
        .alu_z     (alu_z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_z     (out_z),
        .out_op    (out_op)
    );

    function automatic logic [15:0] alu_fn(input logic [7:0] x, input logic [7:0] y,
                                           input logic [1:0] m, input logic [1:0] s);
        logic [15:0] r;
        r = 16'h0000;
        case (s)
            2'b00: case (m)
                2'b00: r = 16'(x) + 16'(y);
                2'b01: r = 16'(x) - 16'(y);
                2'b10: r = 16'(x) * 16'(y);
                default: r = {x, y};
            endcase
            2'b01: case (m)
                2'b00: r = 16'(x) << y[2:0];
                2'b01: r = 16'(x) >> y[2:0];
                2'b10: r = {y, x};
                default: r = {x, x};
            endcase
            2'b10: case (m)
                2'b00: r = {14'd0, x > y, x < y};
                2'b01: r = {15'd0, x == y};
                2'b10: r = 16'((x > y) ? x : y);
                default: r = 16'((x < y) ? x : y);
            endcase
            default: case (m)
                2'b00: r = 16'(x & y);
                2'b01: r = 16'(x | y);
                2'b10: r = 16'(x ^ y);
                default: r = ~{x, y};
            endcase
        endcase
        return r;
    endfunction

    assign alu_z = alu_fn(alu_x, alu_y, alu_m, alu_s);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        outstanding = 0;
        pend        = 1'b0;
        pend_x      = 8'h00;
        pend_y      = 8'h00;
        pend_op     = 4'h0;
        last_lo     = 8'h00;
    endtask

    // One clock cycle: drive inputs, check at the falling edge, advance the model,
    // return 1 time unit after the rising edge.
    task automatic step(input logic r, input logic v, input logic [7:0] x, input logic [7:0] y,
                        input logic [1:0] m, input logic [1:0] s, input logic ch, input logic rd);
        bit          exp_rdy;
        bit          exp_ov;
        bit          acc_e;
        bit          pop_e;
        logic [7:0]  xe;
        logic [15:0] z;
        rst       = r;
        in_valid  = v;
        in_x      = x;
        in_y      = y;
        in_m      = m;
        in_s      = s;
        in_chain  = ch;
        out_ready = rd;
        @(negedge clk);
        exp_rdy = (outstanding < DEPTH);
        exp_ov  = ((exp_q.size() - int'(pend)) > 0);
        check_eq("in_ready", 32'(in_ready), 32'(exp_rdy));
        check_eq("out_valid", 32'(out_valid), 32'(exp_ov));
        if (exp_ov) begin
            check_eq("out_z", 32'(out_z), 32'(exp_q[0][15:0]));
            check_eq("out_op", 32'(out_op), 32'(exp_q[0][19:16]));
        end
        if (pend) begin
            check_eq("alu_x", 32'(alu_x), 32'(pend_x));
            check_eq("alu_y", 32'(alu_y), 32'(pend_y));
            check_eq("alu_op", 32'({alu_s, alu_m}), 32'(pend_op));
        end
        if (r) begin
            model_reset();
        end else begin
            acc_e = v && exp_rdy;
            pop_e = exp_ov && rd;
            if (pop_e) begin
                void'(exp_q.pop_front());
                outstanding--;
            end
            pend = 1'b0;
            if (acc_e) begin
                xe = ch ? last_lo : x;
                z  = alu_fn(xe, y, m, s);
                exp_q.push_back({s, m, z});
                last_lo = z[7:0];
                outstanding++;
                pend    = 1'b1;
                pend_x  = xe;
                pend_y  = y;
                pend_op = {s, m};
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rd);
        step(1'b0, 1'b0, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0, rd);
    endtask

    initial begin
        model_reset();
        step(1'b1, 1'b0, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0, 1'b0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_z", 32'(out_z), 32'd0);
        check_eq("rst_out_op", 32'(out_op), 32'd0);
        check_eq("rst_alu_x", 32'(alu_x), 32'd0);

        // single compare
        step(1'b0, 1'b1, 8'h05, 8'h03, 2'b00, 2'b10, 1'b0, 1'b0);
        check_eq("single_alu_x", 32'(alu_x), 32'h05);
        idle(1'b0);
        check_eq("single_out_valid", 32'(out_valid), 32'd1);
        check_eq("single_out_z", 32'(out_z), 32'h0002);
        check_eq("single_out_op", 32'(out_op), 32'h8);
        idle(1'b1);
        check_eq("single_popped", 32'(out_valid), 32'd0);

        // back-to-back with forwarding
        step(1'b0, 1'b1, 8'h02, 8'h09, 2'b00, 2'b10, 1'b0, 1'b1);
        step(1'b0, 1'b1, 8'hEE, 8'h00, 2'b00, 2'b10, 1'b1, 1'b1);
        check_eq("fwd_alu_x", 32'(alu_x), 32'h01);
        check_eq("fwd_first_z", 32'(out_z), 32'h0001);
        idle(1'b1);
        check_eq("fwd_second_z", 32'(out_z), 32'h0002);
        idle(1'b1);
        idle(1'b1);

        // chain from acc after an idle gap
        step(1'b0, 1'b1, 8'h00, 8'hA5, 2'b11, 2'b00, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);
        step(1'b0, 1'b1, 8'h33, 8'h00, 2'b00, 2'b11, 1'b1, 1'b1);
        check_eq("acc_alu_x", 32'(alu_x), 32'hA5);
        idle(1'b1);
        idle(1'b1);

        // full FIFO then drain
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 8'(i + 1), 8'(i + 7), 2'b00, 2'b00, 1'b0, 1'b0);
        end
        check_eq("full_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 6; i++) idle(1'b1);
        check_eq("drained_in_ready", 32'(in_ready), 32'd1);
        check_eq("drained_out_valid", 32'(out_valid), 32'd0);

        // simultaneous push/pop across pointer wrap
        step(1'b0, 1'b1, 8'h10, 8'h01, 2'b00, 2'b00, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h20, 8'h02, 2'b00, 2'b00, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h30, 8'h03, 2'b00, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) begin
            step(1'b0, 1'b1, 8'($urandom), 8'($urandom), 2'($urandom), 2'($urandom), 1'($urandom), 1'b1);
        end
        for (int i = 0; i < 6; i++) idle(1'b1);

        // reset mid-op
        step(1'b0, 1'b1, 8'h44, 8'h55, 2'b00, 2'b00, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0, 1'b0);
        check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
        check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
        check_eq("midrst_alu_x", 32'(alu_x), 32'd0);
        idle(1'b0);
        idle(1'b0);
        check_eq("midrst_no_push", 32'(out_valid), 32'd0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 3) != 0),
                 8'($urandom), 8'($urandom), 2'($urandom), 2'($urandom),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 8; i++) idle(1'b1);
        check_eq("final_empty", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
